// File: rtl/perceptron_trainer_if.sv
// Sample handshake, perceptron-side bus and per-sample/epoch report of the perceptron trainer.
// The trainer uses the slave modport; the sample source, perceptron and report consumer use the master side.
interface perceptron_trainer_if;
  logic        train_en;
  logic [15:0] init_w1;
  logic [15:0] init_w2;
  logic        init_ld;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_x1;
  logic [15:0] s_x2;
  logic        s_target;
  logic [15:0] neur_IN1;
  logic [15:0] neur_IN2;
  logic [15:0] neur_weight1;
  logic [15:0] neur_weight2;
  logic [15:0] neur_result;
  logic [15:0] neur_weight1_new;
  logic [15:0] neur_weight2_new;
  logic        neur_weight1_ld;
  logic        neur_weight2_ld;
  logic        o_valid;
  logic        o_pred;
  logic        o_err;
  logic [7:0]  epoch_errors;
  logic        epoch_done;
  logic        converged;

  modport slave (
    input  train_en, init_w1, init_w2, init_ld,
    input  s_valid, s_x1, s_x2, s_target,
    output s_ready,
    output neur_IN1, neur_IN2, neur_weight1_new, neur_weight2_new,
    output neur_weight1_ld, neur_weight2_ld,
    input  neur_weight1, neur_weight2, neur_result,
    output o_valid, o_pred, o_err, epoch_errors, epoch_done, converged
  );

  modport master (
    output train_en, init_w1, init_w2, init_ld,
    output s_valid, s_x1, s_x2, s_target,
    input  s_ready,
    input  neur_IN1, neur_IN2, neur_weight1_new, neur_weight2_new,
    input  neur_weight1_ld, neur_weight2_ld,
    output neur_weight1, neur_weight2, neur_result,
    input  o_valid, o_pred, o_err, epoch_errors, epoch_done, converged
  );
endinterface

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: one sample in flight, accept-to-report SETTLE_CYCLES+2 (+1 with weight update).
// s_ready is high only in IDLE; a busy trainer simply leaves s_valid pending at the source.
module perceptron_trainer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LR_SHIFT      = 2,
  parameter int EPOCH_LEN     = 4
) (
  input logic                clk,
  input logic                rst,
  perceptron_trainer_if.slave bus
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, INIT, SETTLE, EVAL, UPDATE, REPORT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [15:0]   x1_q, x1_d, x2_q, x2_d;
  logic [15:0]   nw1_q, nw1_d, nw2_q, nw2_d;
  logic          tgt_q, tgt_d, train_q, train_d;
  logic          pred_q, pred_d, err_q, err_d;
  logic          rep_pred_q, rep_pred_d, rep_err_q, rep_err_d;
  logic [7:0]    smp_cnt_q, smp_cnt_d, acc_q, acc_d, ep_err_q, ep_err_d;
  logic          conv_q, conv_d;
  logic          pred_c, err_c, last_c, ld_c;
  logic [7:0]    acc_inc;

  // Step toward the target class by x >>> LR_SHIFT, saturating to the Q4.12 range.
  function automatic logic [15:0] upd(input logic [15:0] w, input logic [15:0] x, input logic up);
    logic signed [15:0] d;
    logic [16:0]        s;
    d = $signed(x) >>> LR_SHIFT;
    s = up ? ({w[15], w} + {d[15], d}) : ({w[15], w} - {d[15], d});
    if (s[16] != s[15]) upd = s[16] ? 16'h8000 : 16'h7FFF;
    else                upd = s[15:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    nw1_d      = nw1_q;
    nw2_d      = nw2_q;
    tgt_d      = tgt_q;
    train_d    = train_q;
    pred_d     = pred_q;
    err_d      = err_q;
    rep_pred_d = rep_pred_q;
    rep_err_d  = rep_err_q;
    smp_cnt_d  = smp_cnt_q;
    acc_d      = acc_q;
    ep_err_d   = ep_err_q;
    conv_d     = conv_q;
    pred_c     = (bus.neur_result != 16'd0);
    err_c      = (pred_c != tgt_q);
    last_c     = (smp_cnt_q == 8'(EPOCH_LEN - 1));
    acc_inc    = (rep_err_q && acc_q != 8'hFF) ? acc_q + 8'd1 : acc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.init_ld) begin
          nw1_d   = bus.init_w1;
          nw2_d   = bus.init_w2;
          state_d = INIT;
        end else if (bus.s_valid) begin
          x1_d     = bus.s_x1;
          x2_d     = bus.s_x2;
          tgt_d    = bus.s_target;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      INIT: state_d = IDLE;
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = EVAL;
        else                                    settle_d = settle_q + SW'(1);
      end
      EVAL: begin
        pred_d  = pred_c;
        err_d   = err_c;
        train_d = bus.train_en;
        nw1_d   = upd(bus.neur_weight1, x1_q, tgt_q);
        nw2_d   = upd(bus.neur_weight2, x2_q, tgt_q);
        if (bus.train_en && err_c) begin
          state_d = UPDATE;
        end else begin
          rep_pred_d = pred_c;
          rep_err_d  = err_c;
          state_d    = REPORT;
        end
      end
      UPDATE: begin
        rep_pred_d = pred_q;
        rep_err_d  = err_q;
        state_d    = REPORT;
      end
      REPORT: begin
        state_d = IDLE;
        if (rep_err_q) conv_d = 1'b0;
        if (last_c) begin
          ep_err_d  = acc_inc;
          acc_d     = 8'd0;
          smp_cnt_d = 8'd0;
          if (acc_inc == 8'd0 && train_q) conv_d = 1'b1;
        end else begin
          acc_d     = acc_inc;
          smp_cnt_d = smp_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      nw1_q      <= '0;
      nw2_q      <= '0;
      tgt_q      <= 1'b0;
      train_q    <= 1'b0;
      pred_q     <= 1'b0;
      err_q      <= 1'b0;
      rep_pred_q <= 1'b0;
      rep_err_q  <= 1'b0;
      smp_cnt_q  <= '0;
      acc_q      <= '0;
      ep_err_q   <= '0;
      conv_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      nw1_q      <= nw1_d;
      nw2_q      <= nw2_d;
      tgt_q      <= tgt_d;
      train_q    <= train_d;
      pred_q     <= pred_d;
      err_q      <= err_d;
      rep_pred_q <= rep_pred_d;
      rep_err_q  <= rep_err_d;
      smp_cnt_q  <= smp_cnt_d;
      acc_q      <= acc_d;
      ep_err_q   <= ep_err_d;
      conv_q     <= conv_d;
    end
  end

  assign ld_c                 = (state_q == INIT) || (state_q == UPDATE);
  assign bus.s_ready          = (state_q == IDLE) && !rst;
  assign bus.neur_IN1         = x1_q;
  assign bus.neur_IN2         = x2_q;
  assign bus.neur_weight1_ld  = ld_c;
  assign bus.neur_weight2_ld  = ld_c;
  assign bus.neur_weight1_new = ld_c ? nw1_q : 16'd0;
  assign bus.neur_weight2_new = ld_c ? nw2_q : 16'd0;
  assign bus.o_valid          = (state_q == REPORT);
  assign bus.o_pred           = rep_pred_q;
  assign bus.o_err            = rep_err_q;
  assign bus.epoch_done       = (state_q == REPORT) && last_c;
  assign bus.epoch_errors     = ep_err_q;
  assign bus.converged        = conv_q;

endmodule
